uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmit engine for the peripheral bus. It serialises one DATA_W-bit word per frame as start bit, LSB-first data, optional parity and one or two stop bits. An internal per-frame baud divider sets the bit period. Words enter through a valid/ready handshake, so a register-file or FIFO front end can feed the engine back-to-back, and busy/done status is exported for the UART status register.

## Interface
- DATA_W, 8, data bits per frame; legal range 5..9.
- DIV_W, 16, width of the baud divisor input.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- clk_i_w  input  1  system clock; all logic is on its rising edge.
- rst_i_w  input  1  asynchronous, active-low reset.
- en_i_w  input  1  engine enable; when low, all state, counters and outputs hold.
- div_i_w  input  DIV_W  clock cycles per bit minus 1; sampled only at accept.
- parity_odd_i_w  input  1  0 = even parity, 1 = odd parity; sampled at accept (used only with UART_TX_PARITY_EN).
- tx_valid_i_w  input  1  a word is offered on tx_data_i_w.
- tx_data_i_w  input  DATA_W  word to send; sampled only at accept.
- tx_ready_o_r  output  1  engine can accept a word; reset value 1.
- busy_o_r  output  1  a frame is in progress; reset value 0.
- done_o_r  output  1  one-cycle pulse when the final stop bit completes; reset value 0.
- txd_o_r  output  1  serial line, idle high; reset value 1.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Reset enters IDLE.
- Accept occurs on a clock edge where en_i_w && tx_valid_i_w && tx_ready_o_r.
  - tx_ready_o_r is 1 only in IDLE.
  - On accept: latch data, div_i_w and parity_odd_i_w into shadow registers; go to START; drive txd_o_r to 0; set busy_o_r to 1 and tx_ready_o_r to 0.
- Bit timer counts 0..div. Each bit lasts div+1 enabled cycles. A tick is the edge where the timer equals div; the tick resets the timer to 0.
- Tick transitions:
  - START goes to DATA and drives bit 0.
  - DATA drives bits 1..DATA_W-1 in order. After the tick that ends the last bit, DATA goes to PARITY (if compiled in) or to STOP.
  - PARITY drives the parity bit, then goes to STOP.
  - STOP drives 1 for STOP_BITS bit periods. The final tick returns the FSM to IDLE, sets tx_ready_o_r to 1, clears busy_o_r and pulses done_o_r.
- The bit index counter is clog2(DATA_W) bits wide, clears on accept and increments on each DATA tick.
- The shadow registers make the frame immune to changes on div_i_w, tx_data_i_w and parity_odd_i_w after accept.
- tx_valid_i_w asserted while tx_ready_o_r is 0 is ignored; no word is queued.
- With en_i_w low, the timer, FSM, txd_o_r and the handshake all freeze, and no accept can occur. Normal operation resumes on the next enabled cycle.
- Reset asserted mid-frame aborts the frame immediately and asynchronously: txd_o_r=1, tx_ready_o_r=1, busy_o_r=0, done_o_r=0.

## Timing
- Accept at edge N: txd_o_r is 0 from N. The start bit occupies enabled cycles N..N+div.
- Frame length is (1 + DATA_W + P + STOP_BITS) × (div+1) enabled cycles, where P=1 with parity and P=0 without. done_o_r is high in the cycle that follows the final tick.
- Back-to-back frames: tx_ready_o_r rises together with done_o_r. The earliest next accept is on the following edge, so frames are separated by at least one extra idle-high cycle.
- div=0 gives one cycle per bit. div=2^DIV_W−1 must not overflow the timer.

## Configuration
- UART_TX_PARITY_EN defined:
  - the PARITY state exists;
  - even parity bit = XOR of the data bits;
  - odd parity bit = XNOR of the data bits.
- UART_TX_PARITY_EN undefined:
  - the PARITY state and parity logic are not built;
  - parity_odd_i_w is ignored;
  - DATA goes directly to STOP.

## Test plan
- Reset mid-frame, with div=3 and data 0xA5, asserted 10 cycles after accept -> txd_o_r=1, tx_ready_o_r=1, busy_o_r=0 immediately; no done_o_r pulse.
- DATA_W=8, STOP_BITS=1, no parity, div=3, data 0x55 -> line sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; done_o_r pulses once 40 cycles after accept.
- UART_TX_PARITY_EN, data 0x07 -> parity bit 1 with parity_odd_i_w=0, and 0 with parity_odd_i_w=1; frame is 44 cycles at div=3.
- STOP_BITS=2, div=0, two words (0x00 then 0xFF) with tx_valid_i_w held high -> second start bit begins exactly 1 idle cycle after the first frame's 2 stop bits; tx_data_i_w changed mid-frame has no effect.
- en_i_w low for 7 cycles in the middle of the DATA state, div=1 -> txd_o_r and the bit position hold; total accept-to-done time grows by exactly 7 cycles.
- tx_valid_i_w pulsed while busy_o_r=1 -> word ignored; exactly one done_o_r pulse.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit engine.
// Serialises one DATA_W-bit word per frame: start bit, LSB-first data,
// optional parity bit and STOP_BITS stop bits, with a per-frame baud divisor.
// Optional feature macro: UART_TX_PARITY_EN (builds the PARITY state;
// without it parity_odd_i_w is ignored and DATA goes straight to STOP).
module uart_tx_frame #(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              clk_i_w,
    input  logic              rst_i_w,
    input  logic              en_i_w,
    input  logic [DIV_W-1:0]  div_i_w,
    input  logic              parity_odd_i_w,
    input  logic              tx_valid_i_w,
    input  logic [DATA_W-1:0] tx_data_i_w,
    output logic              tx_ready_o_r,
    output logic              busy_o_r,
    output logic              done_o_r,
    output logic              txd_o_r
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  timer, timer_nxt;
    logic [DIV_W-1:0]  div_sh, div_sh_nxt;
    logic [DATA_W-1:0] data_sh, data_sh_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt, idx_inc;
    logic              stop_cnt, stop_cnt_nxt;
    logic              ready_nxt, busy_nxt, done_nxt, txd_nxt;
    logic              tick;

`ifdef UART_TX_PARITY_EN
    logic odd_sh, odd_sh_nxt;
    logic parity_bit;

    // Parity over the shadowed word: XOR for even, XNOR for odd.
    always_comb begin
        parity_bit = (^data_sh) ^ odd_sh;
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd_i_w;
`endif

    // State, counters, shadows and registered outputs; everything holds when disabled.
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            state        <= IDLE;
            timer        <= '0;
            div_sh       <= '0;
            data_sh      <= '0;
            idx          <= '0;
            stop_cnt     <= 1'b0;
            tx_ready_o_r <= 1'b1;
            busy_o_r     <= 1'b0;
            done_o_r     <= 1'b0;
            txd_o_r      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            odd_sh       <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            div_sh       <= div_sh_nxt;
            data_sh      <= data_sh_nxt;
            idx          <= idx_nxt;
            stop_cnt     <= stop_cnt_nxt;
            tx_ready_o_r <= ready_nxt;
            busy_o_r     <= busy_nxt;
            done_o_r     <= done_nxt;
            txd_o_r      <= txd_nxt;
`ifdef UART_TX_PARITY_EN
            odd_sh       <= odd_sh_nxt;
`endif
        end
    end

    // Next-state and next-output logic; defaults hold every register.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        div_sh_nxt   = div_sh;
        data_sh_nxt  = data_sh;
        idx_nxt      = idx;
        stop_cnt_nxt = stop_cnt;
        ready_nxt    = tx_ready_o_r;
        busy_nxt     = busy_o_r;
        done_nxt     = done_o_r;
        txd_nxt      = txd_o_r;
`ifdef UART_TX_PARITY_EN
        odd_sh_nxt   = odd_sh;
`endif
        tick         = (timer == div_sh);
        idx_inc      = idx + 1'b1;

        if (en_i_w) begin
            done_nxt = 1'b0;
            // Timer never exceeds the shadowed divisor, so it cannot overflow.
            if (state != IDLE) begin
                timer_nxt = tick ? '0 : timer + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tx_valid_i_w && tx_ready_o_r) begin
                        data_sh_nxt  = tx_data_i_w;
                        div_sh_nxt   = div_i_w;
`ifdef UART_TX_PARITY_EN
                        odd_sh_nxt   = parity_odd_i_w;
`endif
                        timer_nxt    = '0;
                        idx_nxt      = '0;
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = START;
                        txd_nxt      = 1'b0;
                        busy_nxt     = 1'b1;
                        ready_nxt    = 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state_nxt = DATA;
                        txd_nxt   = data_sh[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        idx_nxt = idx_inc;
                        if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            state_nxt = PARITY;
                            txd_nxt   = parity_bit;
`else
                            state_nxt = STOP;
                            txd_nxt   = 1'b1;
`endif
                        end else begin
                            txd_nxt = data_sh[idx_inc];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            state_nxt = IDLE;
                            ready_nxt = 1'b1;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            stop_cnt_nxt = stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    txd_nxt   = 1'b1;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: per-cycle expected line/status words are queued
// when a word is offered and compared as the DUT shifts the frame out.
module tb_uart_tx_frame;

    logic        clk, rst_n, en, odd;
    logic [15:0] div;
    logic        valid, valid2;
    logic [7:0]  data, data2;
    logic        ready, busy, done, txd;
    logic        ready2, busy2, done2, txd2;

    int checks = 0;
    int errors = 0;

    // Expected {ready, busy, done, txd} per sampled cycle.
    logic [3:0] q1[$];
    logic [3:0] q2[$];

    uart_tx_frame #(.DATA_W(8), .DIV_W(16), .STOP_BITS(1)) dut1 (
        .clk_i_w(clk), .rst_i_w(rst_n), .en_i_w(en), .div_i_w(div),
        .parity_odd_i_w(odd), .tx_valid_i_w(valid), .tx_data_i_w(data),
        .tx_ready_o_r(ready), .busy_o_r(busy), .done_o_r(done), .txd_o_r(txd)
    );

    uart_tx_frame #(.DATA_W(8), .DIV_W(16), .STOP_BITS(2)) dut2 (
        .clk_i_w(clk), .rst_i_w(rst_n), .en_i_w(en), .div_i_w(div),
        .parity_odd_i_w(odd), .tx_valid_i_w(valid2), .tx_data_i_w(data2),
        .tx_ready_o_r(ready2), .busy_o_r(busy2), .done_o_r(done2), .txd_o_r(txd2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed {rdy,busy,done,txd}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference frame: start, LSB-first data, optional parity, stop bits,
    // each held div+1 cycles, followed by the done cycle.
    task automatic push_frame(input int which, input logic [7:0] d, input int dv,
                              input logic p_odd, input int nstop);
        logic bits[$];
        logic [3:0] e;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back((^d) ^ p_odd);
`endif
        for (int s = 0; s < nstop; s++) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int c = 0; c <= dv; c++) begin
                e = {1'b0, 1'b1, 1'b0, bits[b]};
                if (which == 1) q1.push_back(e); else q2.push_back(e);
            end
        end
        if (which == 1) q1.push_back(4'b1011); else q2.push_back(4'b1011);
    endtask

    task automatic send1(input logic [7:0] d, input int dv, input logic p_odd);
        @(negedge clk);
        data  = d;
        div   = 16'(dv);
        odd   = p_odd;
        valid = 1'b1;
        push_frame(1, d, dv, p_odd, 1);
        q1.push_back(4'b1001);
    endtask

    // A disabled stretch repeats whatever the line showed when it started.
    task automatic hold7(input int pos);
        logic [3:0] e;
        e = q1[pos];
        for (int k = 0; k < 7; k++) q1.insert(pos, e);
    endtask

    // Consume q1 one cycle at a time; inputs are scrambled after accept to
    // show the shadow registers isolate the frame.
    task automatic drain1(input string tag, input int freeze_at, input int pulse_at);
        logic [3:0] e;
        int i;
        i = 0;
        while (q1.size() > 0) begin
            @(posedge clk);
            #1;
            e = q1.pop_front();
            chk(tag, {ready, busy, done, txd}, e);
            @(negedge clk);
            valid = (i == pulse_at);
            en    = !(i >= freeze_at && i < freeze_at + 7);
            data  = 8'($urandom);
            div   = 16'($urandom);
            odd   = 1'($urandom);
            i++;
        end
        en = 1'b1;
    endtask

    initial begin
        logic [3:0] e;
        int i;
        int f2;
        clk = 1'b0; rst_n = 1'b0; en = 1'b1; odd = 1'b0; div = '0;
        valid = 1'b0; data = '0; valid2 = 1'b0; data2 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset1", {ready, busy, done, txd}, 4'b1001);
        chk("reset2", {ready2, busy2, done2, txd2}, 4'b1001);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame 0x55, div=3: 40-cycle frame then a single done pulse
        send1(8'h55, 3, 1'b0);
        drain1("frame55", 100000, -1);

        // Parity variants on 0x07
        send1(8'h07, 3, 1'b0);
        drain1("par_even", 100000, -1);
        send1(8'h07, 3, 1'b1);
        drain1("par_odd", 100000, -1);

        // div=0 single-cycle bits, different pattern
        send1(8'hC3, 0, 1'b0);
        drain1("div0", 100000, -1);

        // Enable low for 7 cycles mid-DATA at div=1
        send1(8'h3C, 1, 1'b0);
        hold7(7);
        drain1("freeze", 7, -1);

        // Valid pulsed while busy is ignored
        send1(8'h96, 2, 1'b1);
        drain1("ignore", 100000, 5);
        @(posedge clk);
        #1;
        chk("ignore_idle", {ready, busy, done, txd}, 4'b1001);

        // Two stop bits, div=0, back-to-back with valid held high
`ifdef UART_TX_PARITY_EN
        f2 = 12;
`else
        f2 = 11;
`endif
        @(negedge clk);
        div = '0; data2 = 8'h00; valid2 = 1'b1;
        push_frame(2, 8'h00, 0, 1'b0, 2);
        push_frame(2, 8'hFF, 0, 1'b0, 2);
        q2.push_back(4'b1001);
        i = 0;
        while (q2.size() > 0) begin
            @(posedge clk);
            #1;
            e = q2.pop_front();
            chk("b2b", {ready2, busy2, done2, txd2}, e);
            @(negedge clk);
            if (i == 0) data2 = 8'hFF;
            if (i == f2 + 1) begin
                valid2 = 1'b0;
                data2  = 8'h00;
            end
            i++;
        end

        // Reset mid-frame: 0xA5 at div=3, reset 10 cycles after accept
        @(negedge clk);
        data = 8'hA5; div = 16'd3; valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_accept", {ready, busy, done, txd}, 4'b0100);
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {ready, busy, done, txd}, 4'b1001);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_hold", {ready, busy, done, txd}, 4'b1001);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) begin
            @(posedge clk);
            #1;
            chk("rst_after", {ready, busy, done, txd}, 4'b1001);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
